// File: rtl/lbp_pkg.sv
// lbp_pkg: shared widths and types for the gray-image read-port arbiter.
package lbp_pkg;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
    typedef logic owner_t;
    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;
endpackage

// File: rtl/arb_tag_pipe.sv
// arb_tag_pipe: DEPTH-stage shift register of {valid,owner} tags that follows each read through memory latency.
module arb_tag_pipe
    import lbp_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  owner_t owner,
    output tag_t   head
);
    tag_t stages [DEPTH];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= '{valid: push, owner: owner};
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end
    assign head = stages[DEPTH-1];
endmodule

// File: rtl/gray_port_arbiter.sv
// gray_port_arbiter: round-robin, burst-locked arbiter sharing the gray-image read port between two requesters.
// Define ARB_STATS_EN to add the saturating per-requester beat counters stat_beats0/1.
module gray_port_arbiter
    import lbp_pkg::*;
#(
    parameter int ADDR_W    = lbp_pkg::ADDR_W,
    parameter int DATA_W    = lbp_pkg::DATA_W,
    parameter int BURST_MAX = 9,
    parameter int MEM_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       stat_beats0,
    output logic [15:0]       stat_beats1
`endif
);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    arb_state_t       state, state_nxt;
    owner_t           last_owner, last_owner_nxt, owner;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic             acc0, acc1, acc, burst_end, my_req, other_req;
    tag_t             head;

    assign gnt0      = state == OWN0;
    assign gnt1      = state == OWN1;
    assign acc0      = gnt0 && req0 && mem_ready;
    assign acc1      = gnt1 && req1 && mem_ready;
    assign acc       = acc0 || acc1;
    assign owner     = gnt1;
    assign my_req    = gnt1 ? req1 : req0;
    assign other_req = gnt1 ? req0 : req1;
    assign burst_end = acc && beat_cnt == CNT_W'(BURST_MAX - 1);
    assign mem_req   = acc;
    assign mem_addr  = acc0 ? addr0 : acc1 ? addr1 : '0;

    // Owner gives up the port when it stops requesting, or at a full burst while the other side waits.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        beat_cnt_nxt   = beat_cnt;
        if (state == IDLE) begin
            if (mem_ready && (req0 || req1))
                state_nxt = (req0 && (!req1 || last_owner)) ? OWN0 : OWN1;
        end else if (!gnt0 && !gnt1) begin
            state_nxt = IDLE;
        end else if (!my_req || (burst_end && other_req)) begin
            state_nxt      = !other_req ? IDLE : gnt1 ? OWN0 : OWN1;
            last_owner_nxt = owner;
            beat_cnt_nxt   = '0;
        end else if (acc) begin
            beat_cnt_nxt = burst_end ? '0 : beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    arb_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
        .clk  (clk),
        .reset(reset),
        .push (acc),
        .owner(owner),
        .head (head)
    );

    assign rvalid0 = head.valid && !head.owner;
    assign rvalid1 = head.valid && head.owner;
    assign rdata0  = rvalid0 ? mem_data : '0;
    assign rdata1  = rvalid1 ? mem_data : '0;

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_beats0 <= '0;
            stat_beats1 <= '0;
        end else begin
            if (acc0 && stat_beats0 != 16'hFFFF) stat_beats0 <= stat_beats0 + 16'd1;
            if (acc1 && stat_beats1 != 16'hFFFF) stat_beats1 <= stat_beats1 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_gray_port_arbiter.sv
// tb_gray_port_arbiter: randomized scoreboard bench with a rule-level arbitration model and a latency memory model.
module tb_gray_port_arbiter;
    localparam int AW   = 14;
    localparam int DW   = 8;
    localparam int LAT  = 1;
    localparam int BMAX = 9;

    logic          clk = 1'b0, reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, mem_ready = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_req;
    logic [DW-1:0] rdata0, rdata1, mem_data;
    logic [AW-1:0] mem_addr;
`ifdef ARB_STATS_EN
    logic [15:0]   stat_beats0, stat_beats1;
`endif

    gray_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BMAX), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data)
`ifdef ARB_STATS_EN
        , .stat_beats0(stat_beats0), .stat_beats1(stat_beats1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic [AW-1:0] q0[$], q1[$];
    exp_t          expq0[$], expq1[$];
    int nvec = 0, nerr = 0, cyc = 0;
    int bt0, bt1, rv0, rv1, fa0, la0, fa1, la1;
    int rdy_pct = 100, hold_low = 0;
    logic take0 = 1'b0, take1 = 1'b0;

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return a[7:0] ^ {1'b0, a[13:7]} ^ 8'h5A;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clr();
        bt0 = 0; bt1 = 0; rv0 = 0; rv1 = 0;
        fa0 = -1; la0 = -1; fa1 = -1; la1 = -1;
    endtask

    // Memory: returns mdata(addr) exactly LAT cycles after a strobe, garbage otherwise.
    logic          dv [LAT];
    logic [AW-1:0] da [LAT];
    logic [DW-1:0] junk;
    always @(posedge clk) begin
        dv[0] <= mem_req;
        da[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) begin
            dv[i] <= dv[i-1];
            da[i] <= da[i-1];
        end
        junk <= DW'($urandom);
        cyc  <= cyc + 1;
    end
    assign mem_data = dv[LAT-1] ? mdata(da[LAT-1]) : junk;

    // Requesters hold req/addr until their beat is accepted.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (take0 && q0.size() > 0) void'(q0.pop_front());
            if (take1 && q1.size() > 0) void'(q1.pop_front());
            take0 = 1'b0;
            take1 = 1'b0;
            req0  = q0.size() > 0;
            req1  = q1.size() > 0;
            addr0 = q0.size() > 0 ? q0[0] : AW'($urandom);
            addr1 = q1.size() > 0 ? q1[0] : AW'($urandom);
            mem_ready = hold_low > 0 ? 1'b0 : ($urandom_range(99) < rdy_pct);
            if (hold_low > 0) hold_low--;
        end
    end

    // Reference: -1 idle, 0/1 owner; mlast last owner; mrun beats in current burst.
    int   mg = -1, mlast = 1, mrun = 0, ng;
    logic a0, a1, mine, oth, accm;
    exp_t e;
    always @(negedge clk) begin
        if (reset) begin
            check("reset_outputs", {gnt0, gnt1, rvalid0, rvalid1, mem_req, mem_addr, rdata0, rdata1}, '0);
            mg = -1; mlast = 1; mrun = 0;
            expq0.delete(); expq1.delete();
            take0 = 1'b0; take1 = 1'b0;
        end else begin
            check("grant", {gnt1, gnt0}, mg == 0 ? 2'b01 : mg == 1 ? 2'b10 : 2'b00);
            a0 = gnt0 && req0 && mem_ready;
            a1 = gnt1 && req1 && mem_ready;
            check("mem_req", mem_req, a0 || a1);
            check("mem_addr", mem_addr, a0 ? addr0 : a1 ? addr1 : '0);
            if (a0) begin
                expq0.push_back('{due: cyc + LAT, data: mdata(addr0)});
                take0 = 1'b1; bt0++; la0 = cyc;
                if (fa0 < 0) fa0 = cyc;
            end
            if (a1) begin
                expq1.push_back('{due: cyc + LAT, data: mdata(addr1)});
                take1 = 1'b1; bt1++; la1 = cyc;
                if (fa1 < 0) fa1 = cyc;
            end
            if (rvalid0) rv0++;
            if (rvalid1) rv1++;
            if (expq0.size() > 0 && expq0[0].due == cyc) begin
                e = expq0.pop_front();
                check("rvalid0", rvalid0, 1'b1);
                check("rdata0", rdata0, e.data);
            end else check("rvalid0_quiet", rvalid0, 1'b0);
            if (expq1.size() > 0 && expq1[0].due == cyc) begin
                e = expq1.pop_front();
                check("rvalid1", rvalid1, 1'b1);
                check("rdata1", rdata1, e.data);
            end else check("rvalid1_quiet", rvalid1, 1'b0);
            accm = mem_ready && ((mg == 0 && req0) || (mg == 1 && req1));
            if (mg < 0) begin
                ng = (mem_ready && (req0 || req1)) ? ((req0 && req1) ? 1 - mlast : (req0 ? 0 : 1)) : -1;
            end else begin
                mine = mg == 0 ? req0 : req1;
                oth  = mg == 0 ? req1 : req0;
                if (!mine) ng = oth ? 1 - mg : -1;
                else if (accm && mrun == BMAX - 1) ng = oth ? 1 - mg : mg;
                else ng = mg;
            end
            if (ng != mg) begin
                if (mg >= 0) mlast = mg;
                mrun = 0;
            end else if (accm) mrun = (mrun == BMAX - 1) ? 0 : mrun + 1;
            mg = ng;
        end
    end

    task automatic drain(input string nm, input int maxc);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || expq0.size() > 0 || expq1.size() > 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_drained"}, n < maxc, 1'b1);
        repeat (LAT + 2) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        q0.delete(); q1.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic push_window(input bit who, input int n);
        for (int i = 0; i < n; i++) begin
            if (who) q1.push_back(AW'(((1 + i / 3) << 7) | (1 + i % 3)));
            else q0.push_back(AW'(((1 + i / 3) << 7) | (1 + i % 3)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clr();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        // Single requester, one 3x3 window 0x0081..0x0183.
        clr();
        push_window(0, 9);
        drain("t1", 100);
        check("t1_beats0", bt0, 9);
        check("t1_rvalid0", rv0, 9);
        check("t1_rvalid1", rv1, 0);
        check("t1_back_to_back", la0 - fa0, 8);
        // Tie from reset: 0 first, handover after 9, then back to 0.
        do_reset();
        clr();
        push_window(0, 12);
        push_window(1, 12);
        drain("t2", 200);
        check("t2_first_owner0", fa0 < fa1, 1'b1);
        check("t2_handover", fa1 - fa0, 9);
        check("t2_beats", {bt0, bt1}, {32'd12, 32'd12});
        // Requester 1 alone across two burst rollovers.
        clr();
        push_window(1, 9); push_window(1, 9); push_window(1, 2);
        drain("t3", 200);
        check("t3_rvalid1", rv1, 20);
        check("t3_no_bubble", la1 - fa1, 19);
        // mem_ready stalls mid-burst with a waiting requester.
        clr();
        push_window(0, 9);
        push_window(1, 3);
        for (int n = 0; n < 50 && bt0 < 4; n++) begin @(negedge clk); #1; end
        hold_low = 3;
        drain("t4", 200);
        check("t4_beats0", bt0, 9);
        check("t4_span0", la0 - fa0, 11);
        check("t4_gnt1_after", fa1 - la0, 1);
        // Reset right after an accepted beat drops its return.
        clr();
        push_window(0, 5);
        for (int n = 0; n < 50 && bt0 < 1; n++) begin @(negedge clk); #1; end
        do_reset();
        clr();
        repeat (6) @(negedge clk);
        #1;
        check("t5_no_rvalid", rv0 + rv1, 0);
`ifdef ARB_STATS_EN
        clr();
        push_window(0, 9);
        push_window(1, 5);
        drain("t6", 200);
        check("t6_stat0", stat_beats0, 16'd9);
        check("t6_stat1", stat_beats1, 16'd5);
        do_reset();
        #1;
        check("t6_stat_reset", {stat_beats0, stat_beats1}, 32'd0);
`endif
        // Random traffic with random memory back-pressure.
        clr();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            if (c % 200 == 0) rdy_pct = $urandom_range(30, 100);
            if (q0.size() == 0 && $urandom_range(7) == 0)
                repeat ($urandom_range(1, 25)) q0.push_back(AW'($urandom));
            if (q1.size() == 0 && $urandom_range(7) == 0)
                repeat ($urandom_range(1, 25)) q1.push_back(AW'($urandom));
        end
        rdy_pct = 100;
        drain("t7", 2000);
        check("t7_returns0", rv0, bt0);
        check("t7_returns1", rv1, bt1);
`ifdef ARB_STATS_EN
        check("t7_stat0", stat_beats0, 16'(bt0));
        check("t7_stat1", stat_beats1, 16'(bt1));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
